uart_rx: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the team's uart_tx transmitter, sharing its baud/clock parameterisation.
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe and flags stop-bit framing errors.
- Sits between the board pin and any byte consumer (command parser, FIFO).

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync2.sv | 31 +++
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the uart_tx transmitter.
// Holds default clock/baud constants, frame shape, the bit-timing helpers
// and the receiver state encoding.
package uart_pkg;

  localparam int unsigned FREQ_DEFAULT = 100_000_000;
  localparam int unsigned BAUD_DEFAULT = 9600;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } uart_state_e;

  // clk cycles per serial bit
  function automatic int unsigned ticks_per_bit(input int unsigned freq,
                                                input int unsigned baud);
    return freq / baud;
  endfunction

  // clk cycles to the middle of a bit
  function automatic int unsigned half_bit(input int unsigned freq,
                                           input int unsigned baud);
    return ticks_per_bit(freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk_i  - destination clock
//   rst_ni - synchronous active-low reset, loads RESET_VAL into both flops
//   d_i    - asynchronous input
//   q_o    - synchronised output (second flop)
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Synchronises rx, validates the start bit at mid-bit,
// samples each data bit at mid-bit, checks the stop bit.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-low reset
//   rx        - asynchronous serial line, idles high
//   data      - last correctly framed byte (LSB received first)
//   valid     - one-cycle strobe, data updated this cycle
//   frame_err - one-cycle strobe, stop bit sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD = BAUD_DEFAULT,
  parameter int unsigned FREQ = FREQ_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned TICKS = ticks_per_bit(FREQ, BAUD);
  localparam int unsigned HALF  = half_bit(FREQ, BAUD);
  localparam int unsigned CNT_W = $clog2(DATA_BITS);

  localparam logic [31:0]      TICK_LAST = 32'(TICKS - 1);
  localparam logic [31:0]      HALF_LAST = 32'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);

  if (TICKS < 4) begin : g_bad_ticks
    $error("uart_rx: FREQ/BAUD must be at least 4");
  end

  uart_state_e state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rxs;
  logic             bit_tick;
  logic             stop_tick;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (rx),
    .q_o    (rxs)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!rxs) state_d = ST_START;
      ST_START:   if (timer_q == HALF_LAST) state_d = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:    if (timer_q == TICK_LAST && bit_cnt_q == BIT_LAST) state_d = ST_STOP;
      ST_STOP:    if (timer_q == TICK_LAST) state_d = rxs ? ST_IDLE : ST_RECOVER;
      ST_RECOVER: if (rxs) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and strobes
  always_comb begin
    bit_tick  = (state_q == ST_DATA) && (timer_q == TICK_LAST);
    stop_tick = (state_q == ST_STOP) && (timer_q == TICK_LAST);

    // timer restarts on any state change and on every data-bit sample
    timer_d   = (state_d != state_q || bit_tick) ? '0 : timer_q + 32'd1;

    bit_cnt_d = bit_cnt_q;
    if (state_q == ST_START)
      bit_cnt_d = '0;
    else if (bit_tick)
      bit_cnt_d = bit_cnt_q + 1'b1;

    shift_d   = bit_tick ? {rxs, shift_q[7:1]} : shift_q;
    valid_d   = stop_tick && rxs;
    ferr_d    = stop_tick && !rxs;
    data_d    = valid_d ? shift_q : data_q;
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned TB_FREQ = 160;
  localparam int unsigned TB_BAUD = 10;
  localparam int unsigned BITLEN  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;

  int n_vec = 0;
  int n_err = 0;

  int        nvalid = 0;
  int        nferr  = 0;
  int        nboth  = 0;
  logic [7:0] vlog [0:3];
  time       vtime = 0;
  time       t0    = 0;
  int        lat;

  uart_rx #(.BAUD(TB_BAUD), .FREQ(TB_FREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      if (nvalid < 4) vlog[nvalid] = data;
      nvalid = nvalid + 1;
      vtime  = $time;
    end
    if (frame_err) nferr = nferr + 1;
    if (valid && frame_err) nboth = nboth + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    nvalid = 0;
    nferr  = 0;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BITLEN) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [7:0] bb;
    bb = b;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(bb[i]);
    send_bit(stop);
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Frame 0xA5, good stop, latency
    clear_counts();
    t0 = $time;
    send_byte(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    lat = int'((vtime - t0) / 10);
    check("a5_nvalid", 32'(nvalid), 32'd1);
    check("a5_data", 32'(vlog[0]), 32'hA5);
    check("a5_nferr", 32'(nferr), 32'd0);
    check("a5_lat_in_154pm1", 32'(lat >= 153 && lat <= 155), 32'd1);
    if (!(lat >= 153 && lat <= 155)) $display("  latency observed %0d cycles", lat);

    // Short glitch, then 0x3C
    clear_counts();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_nvalid", 32'(nvalid), 32'd0);
    check("glitch_nferr", 32'(nferr), 32'd0);
    check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("glitch_data_hold", 32'(data), 32'hA5);
    send_byte(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("3c_nvalid", 32'(nvalid), 32'd1);
    check("3c_data", 32'(data), 32'h3C);

    // 0x7E with bad stop, line held low
    clear_counts();
    send_byte(8'h7E, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("7e_nferr", 32'(nferr), 32'd1);
    check("7e_nvalid", 32'(nvalid), 32'd0);
    check("7e_data_hold", 32'(data), 32'h3C);
    check("7e_recover", 32'(dut.state_q), 32'(ST_RECOVER));
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h01, 1'b1);
    repeat (20) @(negedge clk);
    check("01_nvalid", 32'(nvalid), 32'd1);
    check("01_data", 32'(data), 32'h01);
    check("01_nferr", 32'(nferr), 32'd1);

    // Back-to-back 0x00, 0xFF
    clear_counts();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (30) @(negedge clk);
    check("b2b_nvalid", 32'(nvalid), 32'd2);
    check("b2b_first", 32'(vlog[0]), 32'h00);
    check("b2b_second", 32'(vlog[1]), 32'hFF);
    check("b2b_nferr", 32'(nferr), 32'd0);

    // Reset during data bit 3 of 0x5A
    clear_counts();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_ferr", 32'(frame_err), 32'h0);
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_nvalid", 32'(nvalid), 32'd0);
    check("abort_nferr", 32'(nferr), 32'd0);
    send_byte(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    check("c3_nvalid", 32'(nvalid), 32'd1);
    check("c3_data", 32'(data), 32'hC3);
    check("never_both", 32'(nboth), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
